// File: rtl/rriot_timer.sv
// RRIOT interval timer: 8-bit down-counter with 1/8/64/1024 prescale, underflow flag and IRQ.
// Optional macro RRIOT_TIMER_IRQ_EN implements the irqen register; otherwise irq_n is tied high.
module rriot_timer (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       we_n,
   input  logic [3:0] A,
   input  logic [7:0] DI,
   output logic [7:0] DO,
   output logic       OE,
   output logic       irq_n
);
   localparam int unsigned CNT_W = 8;
   localparam int unsigned PRE_W = 10;

   typedef enum logic {ST_PRESCALED = 1'b0, ST_FAST = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [1:0]       div_sel_q, div_sel_d;
   logic [PRE_W-1:0] pre_q, pre_d;
   logic             flag_q, flag_d;
   logic [7:0]       do_d;
   logic             oe_d;

   logic sel_c, wr_c, rd_cnt_c, rd_sts_c, tick_c, underflow_c;

   // Prescaler reload value (divider minus one) for a select code
   function automatic logic [PRE_W-1:0] div_m1(input logic [1:0] sel);
      case (sel)
         2'b00:   div_m1 = PRE_W'(0);
         2'b01:   div_m1 = PRE_W'(7);
         2'b10:   div_m1 = PRE_W'(63);
         default: div_m1 = PRE_W'(1023);
      endcase
   endfunction

   assign sel_c       = enable & A[2];
   assign wr_c        = sel_c & ~we_n;
   assign rd_cnt_c    = sel_c & we_n & ~A[0];
   assign rd_sts_c    = sel_c & we_n & A[0];
   assign tick_c      = (pre_q == '0) || (state_q == ST_FAST);
   assign underflow_c = tick_c && (count_q == '0);

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_PRESCALED;
      else        state_q <= state_d;
   end

   // A write always returns to prescaled mode, even on the underflow edge
   always_comb begin
      state_d = state_q;
      if (wr_c)             state_d = ST_PRESCALED;
      else if (underflow_c) state_d = ST_FAST;
   end

   always_comb begin
      count_d   = count_q;
      div_sel_d = div_sel_q;
      pre_d     = pre_q;
      flag_d    = flag_q;
      do_d      = '0;
      oe_d      = 1'b0;
      if (wr_c) begin
         count_d   = DI;
         div_sel_d = A[1:0];
         pre_d     = div_m1(A[1:0]);
         flag_d    = 1'b0;
      end else begin
         if (tick_c) begin
            pre_d   = (state_q == ST_FAST) ? '0 : div_m1(div_sel_q);
            count_d = count_q - CNT_W'(1);
         end else begin
            pre_d = pre_q - PRE_W'(1);
         end
         // Underflow beats the flag clear of a simultaneous count read
         if (rd_cnt_c)    flag_d = 1'b0;
         if (underflow_c) flag_d = 1'b1;
         if (rd_cnt_c) begin
            do_d = count_q;
            oe_d = 1'b1;
         end else if (rd_sts_c) begin
            do_d = {flag_q, 7'b0};
            oe_d = 1'b1;
         end
      end
   end

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q   <= '0;
         div_sel_q <= 2'b00;
         pre_q     <= '0;
         flag_q    <= 1'b0;
         DO        <= '0;
         OE        <= 1'b0;
      end else begin
         count_q   <= count_d;
         div_sel_q <= div_sel_d;
         pre_q     <= pre_d;
         flag_q    <= flag_d;
         DO        <= do_d;
         OE        <= oe_d;
      end
   end

`ifdef RRIOT_TIMER_IRQ_EN
   logic irqen_q, irqen_d;

   always_comb begin
      irqen_d = irqen_q;
      if (wr_c || rd_cnt_c) irqen_d = A[3];
   end

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) irqen_q <= 1'b0;
      else        irqen_q <= irqen_d;
   end

   assign irq_n = ~(flag_q & irqen_q);
`else
   logic unused_a3;
   assign unused_a3 = A[3];
   assign irq_n     = 1'b1;
`endif

endmodule
